mpsk_mod_tx: RTL and testbench
==============================

// Module: mpsk_mod_tx
// PURPOSE
//  Transmit-side MPSK modulator; the counterpart of the coherent demodulation chain.
//  Accepts one Gray-coded symbol per valid/ready handshake and holds it for SPS samples.
//  Rotates the symbol by a free-running carrier NCO and emits signed I/Q samples every cycle while active.
//  Serves as the stimulus source for the demodulator and as the TX datapath.
// PARAMETERS
//  DATA_WIDTH     16  signed I/Q sample width; LUT amplitude 2^(DATA_WIDTH-1)-1
//  BITS_PER_SYM   2   bits per symbol; M = 2^BITS_PER_SYM; legal range 1..4
//  SPS            8   samples per symbol; must be >= 2
//  PHASE_WIDTH    16  NCO accumulator and phase-word width
//  LUT_ADDR_WIDTH 8   sin/cos LUT address bits; must be <= PHASE_WIDTH
// PORTS
//  clk        in   1               system clock
//  rst        in   1               synchronous, active-high reset
//  en         in   1               block enable; 0 = soft clear
//  fcw        in   PHASE_WIDTH     carrier frequency control word; sampled every cycle
//  s_bits     in   BITS_PER_SYM    Gray-coded symbol bits
//  s_valid    in   1               s_bits valid
//  s_last     in   1               marks the final symbol of a frame
//  s_ready    out  1               symbol accepted when s_valid & s_ready
//  i_out      out  DATA_WIDTH      signed in-phase sample
//  q_out      out  DATA_WIDTH      signed quadrature sample
//  out_valid  out  1               i_out/q_out carry a modulated sample
//  sym_strobe out  1               one-cycle pulse aligned with the first sample of each symbol
//  underrun   out  1               one-cycle pulse: no symbol was available at a boundary mid-frame
// BEHAVIOUR
//  Reset (rst=1): state=IDLE, NCO acc=0, sample cnt=0, all outputs 0.
//  en=0 behaves like reset on the same clock edge, except that the inputs are ignored; en has priority below rst.
//  FSM IDLE -> RUN: s_ready=1 in IDLE; on accept, load the symbol and set cnt=0.
//  In RUN, cnt counts 0..SPS-1. s_ready=1 only when cnt==SPS-1 and the current symbol is not last.
//  At cnt==SPS-1, with the current symbol not last:
//   - s_valid=1: accept the next symbol and set cnt=0, giving a seamless symbol train.
//   - s_valid=0: pulse underrun and go to IDLE.
//  At cnt==SPS-1 with the current symbol last: go to IDLE, with s_ready=0 on that cycle.
//  Symbol index k = gray2bin(s_bits).
//  Symbol phase = (2k+1) * 2^(PHASE_WIDTH-BITS_PER_SYM-1), mod 2^PHASE_WIDTH (odd multiples of pi/M).
//  NCO: acc <= acc + fcw every cycle while en=1, in every state, with unsigned wrap mod 2^PHASE_WIDTH.
//  Total phase = acc + symbol phase (wraps). LUT address = top LUT_ADDR_WIDTH bits, truncated, no rounding.
//  Latency: the accept edge is T0; the phase sum registers at T1; LUT I/Q registers at T2.
//  out_valid and sym_strobe are delayed by that same 2-cycle pipeline.
//  out_valid=1 for exactly SPS cycles per accepted symbol; when out_valid=0, i_out=q_out=0.
//  A single symbol arriving in IDLE yields SPS valid samples, then out_valid=0.
//  rst or en=0 mid-symbol flushes the pipeline. On the next edge, outputs are 0 and the partial symbol is dropped.
// CONFIGURATION
//  MPSK_DIFF_ENC_EN defined: differential encoding, k_tx = (k_prev + k) mod M.
//   k_prev is cleared to 0 by rst, by en=0, and on every IDLE->RUN accept (frame start).
//  MPSK_DIFF_ENC_EN undefined: k_tx = k; no k_prev register.
// STRUCTURE
//  Package mpsk_pkg:
//   - state enum {IDLE, RUN}
//   - function gray2bin
//   - localparams M and SYM_PHASE_LSB = PHASE_WIDTH-BITS_PER_SYM-1
//  Sub-module mpsk_sincos_lut: registered full-wave cos/sin ROM, parameters LUT_ADDR_WIDTH and DATA_WIDTH.
//   - Entry n = round((2^(DATA_WIDTH-1)-1) * cos/sin(2*pi*n/2^LUT_ADDR_WIDTH)).
// TESTING
//  T1 fcw=0, QPSK, frame of Gray symbols 00,01,11,10 with s_last on the 4th:
//   -> I/Q = (+23170,+23170), (-23170,+23170), (-23170,-23170), (+23170,-23170).
//   -> Each symbol is held for 8 samples, sym_strobe fires every 8th cycle, and out_valid drops after 32 samples.
//  T2 s_valid held high with no s_last:
//   -> s_ready pulses once every 8 cycles, with no out_valid gap across symbols.
//  T3 s_valid dropped at a mid-frame boundary:
//   -> one underrun pulse, out_valid=0 two cycles later, and the FSM returns to IDLE.
//  T4 fcw=2^14 with a single symbol 00:
//   -> the phase advances 90 deg per sample, so I/Q rotates (+23170,+23170) -> (-23170,+23170) -> ...
//  T5 rst and then en=0 each asserted at cnt=3:
//   -> all outputs are 0 on the next edge, and the next accept restarts cleanly at cnt=0 with the first output at T2.
//  T6 MPSK_DIFF_ENC_EN, fcw=0, symbols 01,01 (k=1,1):
//   -> transmitted k = 1 then 2, i.e. (-23170,+23170) then (-23170,-23170).

Source files
------------

// File: rtl/mpsk_pkg.sv
// Shared types and helpers for the MPSK transmit modulator.
package mpsk_pkg;

    // Default symbol geometry (QPSK on a 16-bit phase word).
    localparam int DEF_BITS_PER_SYM = 2;
    localparam int DEF_PHASE_WIDTH  = 16;
    localparam int M                = 2 ** DEF_BITS_PER_SYM;
    localparam int SYM_PHASE_LSB    = DEF_PHASE_WIDTH - DEF_BITS_PER_SYM - 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Gray to binary for up to 4 bits; unused upper bits must be zero.
    function automatic logic [3:0] gray2bin(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        for (int i = 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/mpsk_mod_tx_if.sv
// Symbol-in / I-Q-out bus of the MPSK modulator.
// master: symbol source and sample sink; slave: the modulator.
interface mpsk_mod_tx_if #(
    parameter int DATA_WIDTH   = 16,
    parameter int BITS_PER_SYM = 2,
    parameter int PHASE_WIDTH  = 16
);
    logic [PHASE_WIDTH-1:0]       fcw;
    logic [BITS_PER_SYM-1:0]      s_bits;
    logic                         s_valid;
    logic                         s_last;
    logic                         s_ready;
    logic signed [DATA_WIDTH-1:0] i_out;
    logic signed [DATA_WIDTH-1:0] q_out;
    logic                         out_valid;
    logic                         sym_strobe;
    logic                         underrun;

    modport master (
        output fcw, s_bits, s_valid, s_last,
        input  s_ready, i_out, q_out, out_valid, sym_strobe, underrun
    );

    modport slave (
        input  fcw, s_bits, s_valid, s_last,
        output s_ready, i_out, q_out, out_valid, sym_strobe, underrun
    );
endinterface

// File: rtl/mpsk_sincos_lut.sv
// Registered full-wave cos/sin ROM, amplitude 2^(DATA_WIDTH-1)-1, rounded to nearest.
module mpsk_sincos_lut #(
    parameter int LUT_ADDR_WIDTH = 8,
    parameter int DATA_WIDTH     = 16
) (
    input  logic                             clk,
    input  logic [LUT_ADDR_WIDTH-1:0]        addr,
    output logic signed [DATA_WIDTH-1:0]     cos_q,
    output logic signed [DATA_WIDTH-1:0]     sin_q
);
    localparam int  DEPTH  = 2 ** LUT_ADDR_WIDTH;
    localparam real AMP    = (2.0 ** (DATA_WIDTH - 1)) - 1.0;
    localparam real TWO_PI = 6.283185307179586;

    logic signed [DATA_WIDTH-1:0] cos_rom [DEPTH];
    logic signed [DATA_WIDTH-1:0] sin_rom [DEPTH];

    // Table contents are elaboration-time constants, one entry per phase step.
    for (genvar n = 0; n < DEPTH; n++) begin : g_rom
        localparam real ANG = TWO_PI * real'(n) / real'(DEPTH);
        localparam real CV  = AMP * $cos(ANG);
        localparam real SV  = AMP * $sin(ANG);
        localparam int  CI  = $rtoi((CV >= 0.0) ? CV + 0.5 : CV - 0.5);
        localparam int  SI  = $rtoi((SV >= 0.0) ? SV + 0.5 : SV - 0.5);
        assign cos_rom[n] = DATA_WIDTH'(CI);
        assign sin_rom[n] = DATA_WIDTH'(SI);
    end

    // Registered ROM read.
    // NOTE: ROM output registers carry no reset; the consumer qualifies them with a reset valid bit.
    always_ff @(posedge clk) begin
        cos_q <= cos_rom[addr];
        sin_q <= sin_rom[addr];
    end
endmodule

// File: rtl/mpsk_mod_tx.sv
// MPSK transmit modulator: symbol handshake, SPS-sample hold, carrier NCO rotation,
// two-stage phase -> cos/sin pipeline.
// Build option: define MPSK_DIFF_ENC_EN for differential symbol encoding.
module mpsk_mod_tx
    import mpsk_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int BITS_PER_SYM   = DEF_BITS_PER_SYM,
    parameter int SPS            = 8,
    parameter int PHASE_WIDTH    = DEF_PHASE_WIDTH,
    parameter int LUT_ADDR_WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    mpsk_mod_tx_if.slave bus
);
    localparam int                CNT_W    = $clog2(SPS);
    localparam int                SYM_LSB  = PHASE_WIDTH - BITS_PER_SYM - 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SPS - 1);

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [BITS_PER_SYM-1:0]   sym_k_q, sym_k_d;
    logic                      last_q, last_d;
    logic [PHASE_WIDTH-1:0]    acc_q, acc_d;
    logic [PHASE_WIDTH-1:0]    phase_q, phase_d;
    logic                      vld1_q, vld1_d, stb1_q, stb1_d;
    logic                      vld2_q, vld2_d, stb2_q, stb2_d;
    logic                      under_q, under_d;

    logic                      s_ready_c;
    logic                      load;
    logic [3:0]                k_bin4;
    logic [BITS_PER_SYM-1:0]   k_in;
    logic [BITS_PER_SYM-1:0]   k_tx;
    logic [PHASE_WIDTH-1:0]    sym_phase;
    logic signed [DATA_WIDTH-1:0] lut_cos, lut_sin;

    assign k_bin4    = gray2bin(4'(bus.s_bits));
    assign k_in      = k_bin4[BITS_PER_SYM-1:0];
    assign sym_phase = PHASE_WIDTH'({sym_k_q, 1'b1}) << SYM_LSB;

`ifdef MPSK_DIFF_ENC_EN
    logic [BITS_PER_SYM-1:0] k_prev_q, k_prev_d;

    // Differential encoding: accumulate onto the previous symbol, restarting at frame start.
    always_comb begin
        k_tx     = ((state_q == IDLE) ? '0 : k_prev_q) + k_in;
        k_prev_d = k_prev_q;
        if (load) k_prev_d = k_tx;
        if (!en)  k_prev_d = '0;
    end

    // Previous transmitted symbol index.
    always_ff @(posedge clk) begin
        if (rst) k_prev_q <= '0;
        else     k_prev_q <= k_prev_d;
    end
`else
    assign k_tx = k_in;
`endif

    // Symbol FSM: accept, hold for SPS samples, chain, underrun or end of frame.
    always_comb begin
        // NOTE: every variable gets a default first, so no path can infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        sym_k_d   = sym_k_q;
        last_d    = last_q;
        under_d   = 1'b0;
        s_ready_c = 1'b0;
        load      = 1'b0;
        case (state_q)
            IDLE: begin
                s_ready_c = 1'b1;
                load      = bus.s_valid;
            end
            RUN: begin
                if (cnt_q == CNT_LAST) begin
                    if (last_q) begin
                        state_d = IDLE;
                    end else begin
                        s_ready_c = 1'b1;
                        if (bus.s_valid) begin
                            load = 1'b1;
                        end else begin
                            under_d = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            state_d = RUN;
            cnt_d   = '0;
            sym_k_d = k_tx;
            last_d  = bus.s_last;
        end
        // Disable acts as a soft clear and ignores the symbol inputs.
        if (!en) begin
            state_d   = IDLE;
            cnt_d     = '0;
            sym_k_d   = '0;
            last_d    = 1'b0;
            under_d   = 1'b0;
            s_ready_c = 1'b0;
            load      = 1'b0;
        end
    end

    // NCO and phase/valid pipeline next values.
    always_comb begin
        acc_d   = acc_q + bus.fcw;
        phase_d = acc_q + sym_phase;
        vld1_d  = (state_q == RUN);
        stb1_d  = (state_q == RUN) && (cnt_q == '0);
        vld2_d  = vld1_q;
        stb2_d  = stb1_q;
        if (!en) begin
            acc_d   = '0;
            phase_d = '0;
            vld1_d  = 1'b0;
            stb1_d  = 1'b0;
            vld2_d  = 1'b0;
            stb2_d  = 1'b0;
        end
    end

    // State, NCO and pipeline registers.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge values.
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sym_k_q <= '0;
            last_q  <= 1'b0;
            acc_q   <= '0;
            phase_q <= '0;
            vld1_q  <= 1'b0;
            stb1_q  <= 1'b0;
            vld2_q  <= 1'b0;
            stb2_q  <= 1'b0;
            under_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sym_k_q <= sym_k_d;
            last_q  <= last_d;
            acc_q   <= acc_d;
            phase_q <= phase_d;
            vld1_q  <= vld1_d;
            stb1_q  <= stb1_d;
            vld2_q  <= vld2_d;
            stb2_q  <= stb2_d;
            under_q <= under_d;
        end
    end

    mpsk_sincos_lut #(
        .LUT_ADDR_WIDTH (LUT_ADDR_WIDTH),
        .DATA_WIDTH     (DATA_WIDTH)
    ) u_lut (
        .clk   (clk),
        .addr  (phase_q[PHASE_WIDTH-1 -: LUT_ADDR_WIDTH]),
        .cos_q (lut_cos),
        .sin_q (lut_sin)
    );

    assign bus.s_ready    = s_ready_c & ~rst;
    assign bus.i_out      = vld2_q ? lut_cos : '0;
    assign bus.q_out      = vld2_q ? lut_sin : '0;
    assign bus.out_valid  = vld2_q;
    assign bus.sym_strobe = stb2_q;
    assign bus.underrun   = under_q;
endmodule

// File: tb/tb_mpsk_mod_tx.sv
// Scoreboard bench for mpsk_mod_tx: expected samples are queued on each accepted
// symbol and compared as the modulator emits them.
module tb_mpsk_mod_tx;
    localparam int DW   = 16;
    localparam int BITS = 2;
    localparam int SPS  = 8;
    localparam int PW   = 16;
    localparam int LAW  = 8;

    logic clk = 1'b0;
    logic rst;
    logic en;
    always #5 clk = ~clk;

    mpsk_mod_tx_if #(.DATA_WIDTH(DW), .BITS_PER_SYM(BITS), .PHASE_WIDTH(PW)) bus_if ();

    mpsk_mod_tx #(
        .DATA_WIDTH(DW), .BITS_PER_SYM(BITS), .SPS(SPS),
        .PHASE_WIDTH(PW), .LUT_ADDR_WIDTH(LAW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .bus (bus_if)
    );

    typedef struct {
        logic signed [DW-1:0] i;
        logic signed [DW-1:0] q;
        logic                 stb;
    } exp_t;

    exp_t          sb_q[$];
    exp_t          mon_e;
    int            n_tests = 0;
    int            n_fail  = 0;
    int            underrun_cnt = 0;
    int            run_len = 0;
    int            last_run = 0;
    bit            mon_en = 1'b0;
    logic [PW-1:0] acc_m;
`ifdef MPSK_DIFF_ENC_EN
    logic [BITS-1:0] kprev_m = '0;
`endif

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Ideal rounded LUT amplitude for a given address.
    function automatic int amp(input int addr, input bit is_sin);
        real a, v;
        a = 6.283185307179586 * real'(addr) / (2.0 ** LAW);
        v = 32767.0 * (is_sin ? $sin(a) : $cos(a));
        return $rtoi((v >= 0.0) ? v + 0.5 : v - 0.5);
    endfunction

    // Reference NCO: free-running accumulator, cleared by rst or en=0.
    always @(posedge clk) begin
        if (rst || !en) acc_m <= '0;
        else            acc_m <= acc_m + bus_if.fcw;
    end

    // Output monitor: pops the scoreboard on every valid sample.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus_if.underrun) underrun_cnt++;
            if (bus_if.out_valid) begin
                run_len++;
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_sample", sb_q.size(), 1);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("i_out", bus_if.i_out, mon_e.i);
                    check("q_out", bus_if.q_out, mon_e.q);
                    check("sym_strobe", bus_if.sym_strobe, mon_e.stb);
                end
            end else begin
                if (run_len > 0) begin
                    last_run = run_len;
                    run_len  = 0;
                end
                check("i_idle", bus_if.i_out, 0);
                check("q_idle", bus_if.q_out, 0);
                check("strobe_idle", bus_if.sym_strobe, 0);
            end
        end
    end

    // Queue the SPS samples of an accepted symbol; acc_pre is the accumulator before the accept edge.
    task automatic push_sym(input logic [1:0] bits, input bit first,
                            input logic [PW-1:0] acc_pre, input logic [PW-1:0] f);
        logic [1:0]    k, ktx;
        logic [PW-1:0] ph, sym;
        exp_t          e;
        k = {bits[1], bits[1] ^ bits[0]};
`ifdef MPSK_DIFF_ENC_EN
        ktx     = first ? k : kprev_m + k;
        kprev_m = ktx;
`else
        ktx = k;
        if (first) ktx = k;
`endif
        sym = PW'({ktx, 1'b1}) << (PW - BITS - 1);
        for (int j = 0; j < SPS; j++) begin
            ph    = acc_pre + f * PW'(j + 1) + sym;
            e.i   = DW'(amp(int'(ph[PW-1 -: LAW]), 1'b0));
            e.q   = DW'(amp(int'(ph[PW-1 -: LAW]), 1'b1));
            e.stb = (j == 0);
            sb_q.push_back(e);
        end
    endtask

    // Present a symbol and wait (bounded) for it to be accepted; returns at the accept edge.
    task automatic send(input logic [1:0] bits, input logic last, input bit first, output int waited);
        waited = 0;
        @(negedge clk);
        bus_if.s_valid = 1'b1;
        bus_if.s_bits  = bits;
        bus_if.s_last  = last;
        while (!bus_if.s_ready && waited < 4 * SPS) begin
            @(negedge clk);
            waited++;
        end
        if (bus_if.s_ready) begin
            push_sym(bits, first, acc_m, bus_if.fcw);
            @(posedge clk);
        end else begin
            check("accept_timeout", waited, 0);
        end
    endtask

    task automatic drop();
        bus_if.s_valid = 1'b0;
        bus_if.s_last  = 1'b0;
    endtask

    task automatic drain(input string tag, input int exp_run);
        repeat (SPS + 4) @(posedge clk);
        #1;
        check({tag, "_sb_empty"}, sb_q.size(), 0);
        check({tag, "_valid_run"}, last_run, exp_run);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, u0;
        bit seen;
        rst = 1'b1;
        en  = 1'b1;
        bus_if.fcw = '0;
        drop();
        bus_if.s_bits = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", bus_if.out_valid, 0);
        check("rst_i_out", bus_if.i_out, 0);
        check("rst_q_out", bus_if.q_out, 0);
        check("rst_strobe", bus_if.sym_strobe, 0);
        check("rst_underrun", bus_if.underrun, 0);
        check("rst_s_ready", bus_if.s_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;
        #1;
        check("idle_s_ready", bus_if.s_ready, 1);

        // T1: QPSK frame 00,01,11,10 at fcw=0.
        u0 = underrun_cnt;
        send(2'b00, 1'b0, 1'b1, w);
        send(2'b01, 1'b0, 1'b0, w);
        check("t1_ready_spacing", w, SPS - 1);
        send(2'b11, 1'b0, 1'b0, w);
        send(2'b10, 1'b1, 1'b0, w);
        #1 drop();
        drain("t1", 4 * SPS);
        check("t1_no_underrun", underrun_cnt - u0, 0);

        // T2: continuous symbol train with a nonzero carrier.
        bus_if.fcw = 16'h0123;
        send(2'b10, 1'b0, 1'b1, w);
        for (int n = 0; n < 4; n++) begin
            send(2'(n), 1'b0, 1'b0, w);
            check("t2_ready_spacing", w, SPS - 1);
        end
        send(2'b11, 1'b1, 1'b0, w);
        check("t2_ready_spacing_last", w, SPS - 1);
        #1 drop();
        drain("t2", 6 * SPS);

        // T3: mid-frame underrun.
        bus_if.fcw = '0;
        u0 = underrun_cnt;
        send(2'b01, 1'b0, 1'b1, w);
        send(2'b11, 1'b0, 1'b0, w);
        #1 drop();
        seen = 1'b0;
        for (int c = 0; c < 4 * SPS && !seen; c++) begin
            @(negedge clk);
            seen = bus_if.underrun;
        end
        check("t3_underrun_seen", seen, 1);
        check("t3_idle_ready", bus_if.s_ready, 1);
        check("t3_valid_at_pulse", bus_if.out_valid, 1);
        @(negedge clk);
        check("t3_valid_plus1", bus_if.out_valid, 1);
        check("t3_underrun_one_cycle", bus_if.underrun, 0);
        @(negedge clk);
        check("t3_valid_plus2", bus_if.out_valid, 0);
        drain("t3", 2 * SPS);
        check("t3_underrun_count", underrun_cnt - u0, 1);

        // T4: quarter-turn carrier with a single symbol.
        bus_if.fcw = 16'h4000;
        send(2'b00, 1'b1, 1'b1, w);
        #1 drop();
        drain("t4", SPS);

        // T5a: rst at cnt=3 flushes, then a clean restart with two-cycle latency.
        bus_if.fcw = 16'h0800;
        send(2'b01, 1'b0, 1'b1, w);
        #1 drop();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        sb_q.delete();
        #1;
        check("t5r_out_valid", bus_if.out_valid, 0);
        check("t5r_i_out", bus_if.i_out, 0);
        check("t5r_q_out", bus_if.q_out, 0);
        check("t5r_strobe", bus_if.sym_strobe, 0);
        check("t5r_underrun", bus_if.underrun, 0);
        check("t5r_s_ready", bus_if.s_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        send(2'b10, 1'b1, 1'b1, w);
        #1 drop();
        check("t5r_lat_t0", bus_if.out_valid, 0);
        @(posedge clk); #1;
        check("t5r_lat_t1", bus_if.out_valid, 0);
        @(posedge clk); #1;
        check("t5r_lat_t2", bus_if.out_valid, 1);
        check("t5r_lat_t2_strobe", bus_if.sym_strobe, 1);
        drain("t5r", SPS);

        // T5b: en=0 at cnt=3 flushes and ignores inputs.
        send(2'b11, 1'b0, 1'b1, w);
        #1 drop();
        repeat (3) @(posedge clk);
        @(negedge clk);
        en = 1'b0;
        bus_if.s_valid = 1'b1;
        @(posedge clk);
        sb_q.delete();
        #1;
        check("t5e_out_valid", bus_if.out_valid, 0);
        check("t5e_i_out", bus_if.i_out, 0);
        check("t5e_q_out", bus_if.q_out, 0);
        check("t5e_strobe", bus_if.sym_strobe, 0);
        check("t5e_s_ready", bus_if.s_ready, 0);
        @(posedge clk); #1;
        check("t5e_ignored_valid", bus_if.out_valid, 0);
        @(negedge clk);
        drop();
        en = 1'b1;
        send(2'b01, 1'b1, 1'b1, w);
        #1 drop();
        check("t5e_lat_t0", bus_if.out_valid, 0);
        @(posedge clk); #1;
        check("t5e_lat_t1", bus_if.out_valid, 0);
        @(posedge clk); #1;
        check("t5e_lat_t2", bus_if.out_valid, 1);
        drain("t5e", SPS);

        // T6: repeated symbol 01 (differential build accumulates to k=2).
        bus_if.fcw = '0;
        send(2'b01, 1'b0, 1'b1, w);
        send(2'b01, 1'b1, 1'b0, w);
        #1 drop();
        drain("t6", 2 * SPS);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
